// File: rtl/count_capture_unit_pkg.sv
// Shared sizing for the count capture unit and its FIFO.
// CAP_WRAP_TAG_EN widens each stored sample with a counter wrap tag.
package count_capture_unit_pkg;

    localparam int CAP_CNT_W  = 5;
    localparam int CAP_DEPTH  = 4;
    localparam int CAP_WRAP_W = 3;

    function automatic int cap_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    localparam int CAP_PTR_W = cap_clog2(CAP_DEPTH);

`ifdef CAP_WRAP_TAG_EN
    localparam int CAP_DW = CAP_CNT_W + CAP_WRAP_W;
`else
    localparam int CAP_DW = CAP_CNT_W;
`endif

endpackage

// File: rtl/count_capture_unit_fifo.sv
// cap_sync_fifo: generic first-word-fall-through FIFO with level/full/empty.
// Head output holds the last popped word while empty.
module cap_sync_fifo
    import count_capture_unit_pkg::*;
#(
    parameter int DW    = 5,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push_i,
    input  logic [DW-1:0]               din_i,
    input  logic                        pop_i,
    output logic [DW-1:0]               dout_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [cap_clog2(DEPTH):0]   level_o
);

    localparam int AW = cap_clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
    logic [DW-1:0] last_q, last_d;
    logic [DW-1:0] head_w;
    logic          do_push, do_pop;

    assign level_o = wr_q - rd_q;
    assign empty_o = (wr_q == rd_q);
    assign full_o  = (level_o == FULL_LVL);
    assign head_w  = mem_q[rd_q[AW-1:0]];
    assign dout_o  = empty_o ? last_q : head_w;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_d   = do_push ? wr_q + ONE : wr_q;
        rd_d   = do_pop ? rd_q + ONE : rd_q;
        last_d = do_pop ? head_w : last_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q   <= '0;
            rd_q   <= '0;
            last_q <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            last_q <= last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/count_capture_unit.sv
// Timestamps async trigger edges with the counter value into a FWFT FIFO.
// Define CAP_WRAP_TAG_EN to prefix each sample with a counter wrap tag.
module count_capture_unit
    import count_capture_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CAP_CNT_W-1:0] cnt_in,
    input  logic                 trig_in,
    input  logic                 cap_en,
    output logic [CAP_DW-1:0]    cap_data,
    output logic                 cap_valid,
    input  logic                 cap_ready,
    output logic [CAP_PTR_W:0]   fifo_level,
    output logic                 overflow,
    input  logic                 clr_ovf
);

    logic              s1_q, s2_q, s3_q;
    logic              edge_w, push_w, pop_w;
    logic              full_w, empty_w;
    logic              ovf_q, ovf_d;
    logic [CAP_DW-1:0] sample_w;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= trig_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign edge_w = s2_q & ~s3_q;
    assign push_w = edge_w & cap_en;
    assign pop_w  = cap_valid & cap_ready;

`ifdef CAP_WRAP_TAG_EN
    logic [CAP_CNT_W-1:0]  cnt_q;
    logic [CAP_WRAP_W-1:0] tag_q, tag_d;
    logic                  wrap_w;

    assign wrap_w   = (cnt_q == '1) && (cnt_in == '0);
    assign tag_d    = wrap_w ? tag_q + {{(CAP_WRAP_W-1){1'b0}}, 1'b1} : tag_q;
    // Sample sees the tag before this cycle's increment.
    assign sample_w = {tag_q, cnt_in};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            tag_q <= '0;
        end else begin
            cnt_q <= cnt_in;
            tag_q <= tag_d;
        end
    end
`else
    assign sample_w = cnt_in;
`endif

    // Set has priority over clear.
    always_comb begin
        ovf_d = ovf_q;
        if (clr_ovf) ovf_d = 1'b0;
        if (push_w & full_w & ~pop_w) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    assign overflow  = ovf_q;
    assign cap_valid = ~empty_w;

    cap_sync_fifo #(
        .DW    (CAP_DW),
        .DEPTH (CAP_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_w),
        .din_i   (sample_w),
        .pop_i   (cap_ready),
        .dout_o  (cap_data),
        .full_o  (full_w),
        .empty_o (empty_w),
        .level_o (fifo_level)
    );

endmodule
